// File: rtl/ftdi_bus_arbiter.sv
// ftdi_bus_arbiter
//   Owns the shared 8-bit FTDI FIFO bus. It arbitrates between the host-read path
//   (PC->FPGA bytes to the packet parser) and the host-write path (FPGA->PC bytes
//   from the packet builder). It also sequences the RD#/WR# strobes and the ADBUS
//   direction turnaround.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   ftdi_rxf, ftdi_txe   FTDI RXF#/TXE# flags (active low, asynchronous)
//   adbus_in/out/oe      ADBUS input value, drive value, drive enable
//   ftdi_rd, ftdi_wr     FTDI RD#/WR# strobes (active low)
//   rx_data/valid/ready  received byte stream towards the parser
//   tx_data/valid/ready  transmit byte stream from the builder (tx_ready = accept pulse)
//   rd_count, wr_count   wrapping byte counters since reset
module ftdi_bus_arbiter #(
    parameter int unsigned RD_PULSE   = 3,
    parameter int unsigned WR_PULSE   = 2,
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned FLAG_BLANK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ftdi_rxf,
    input  logic        ftdi_txe,
    input  logic [7:0]  adbus_in,
    output logic [7:0]  adbus_out,
    output logic        adbus_oe,
    output logic        ftdi_rd,
    output logic        ftdi_wr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int unsigned MAX_P0  = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int unsigned MAX_P   = (MAX_P0 > TURNAROUND) ? MAX_P0 : TURNAROUND;
    localparam int unsigned CNT_W   = $clog2(MAX_P + 1);
    localparam int unsigned BLANK_W = (FLAG_BLANK < 2) ? 1 : $clog2(FLAG_BLANK + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        RD_DONE,
        WR_SETUP,
        WR_LOW,
        WR_HOLD,
        TURN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               rxf_meta;
    logic               rxf_s;
    logic               txe_meta;
    logic               txe_s;
    logic [BLANK_W-1:0] rd_blank;
    logic [BLANK_W-1:0] wr_blank;
    logic               last_rd;
    logic [7:0]         rd_cap;
    logic               rd_ok;
    logic               wr_ok;
    logic               rd_last;
    logic               wr_last;
    logic               turn_last;

    always_comb begin
        rd_last   = (cnt == CNT_W'(RD_PULSE - 1));
        wr_last   = (cnt == CNT_W'(WR_PULSE - 1));
        turn_last = (cnt == CNT_W'(TURNAROUND - 1));
        // A read may start while a held byte is being accepted this cycle.
        rd_ok     = !rxf_s && (rd_blank == '0) && (!rx_valid || rx_ready);
        wr_ok     = !txe_s && (wr_blank == '0) && tx_valid;
    end

    // State register plus phase counter; the counter restarts on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_ok && wr_ok)
                    state_next = last_rd ? WR_SETUP : RD_LOW;
                else if (rd_ok)
                    state_next = RD_LOW;
                else if (wr_ok)
                    state_next = WR_SETUP;
            end
            RD_LOW:   if (rd_last) state_next = RD_DONE;
            RD_DONE:  state_next = IDLE;
            WR_SETUP: state_next = WR_LOW;
            WR_LOW:   if (wr_last) state_next = WR_HOLD;
            WR_HOLD:  state_next = TURN;
            TURN:     if (turn_last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        ftdi_rd  = 1'b1;
        ftdi_wr  = 1'b1;
        adbus_oe = 1'b0;
        tx_ready = 1'b0;
        case (state)
            RD_LOW:   ftdi_rd  = 1'b0;
            WR_SETUP: tx_ready = 1'b1;
            WR_LOW: begin
                ftdi_wr  = 1'b0;
                adbus_oe = 1'b1;
            end
            WR_HOLD:  adbus_oe = 1'b1;
            default: begin
                ftdi_rd  = 1'b1;
                ftdi_wr  = 1'b1;
            end
        endcase
    end

    // Flag synchronizers, capture path, handshakes, blanking and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxf_meta  <= 1'b1;
            rxf_s     <= 1'b1;
            txe_meta  <= 1'b1;
            txe_s     <= 1'b1;
            rd_blank  <= '0;
            wr_blank  <= '0;
            last_rd   <= 1'b0;
            rd_cap    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            adbus_out <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            rxf_meta <= ftdi_rxf;
            rxf_s    <= rxf_meta;
            txe_meta <= ftdi_txe;
            txe_s    <= txe_meta;

            if (state == RD_LOW && rd_last)
                rd_cap <= adbus_in;

            // Setting rx_valid in RD_DONE takes priority over a same-cycle accept.
            if (state == RD_DONE) begin
                rx_data  <= rd_cap;
                rx_valid <= 1'b1;
                rd_count <= rd_count + 16'd1;
                rd_blank <= BLANK_W'(FLAG_BLANK);
                last_rd  <= 1'b1;
            end else begin
                if (rx_valid && rx_ready)
                    rx_valid <= 1'b0;
                if (rd_blank != '0)
                    rd_blank <= rd_blank - BLANK_W'(1);
            end

            if (state == WR_SETUP)
                adbus_out <= tx_data;

            if (state == WR_HOLD) begin
                wr_count <= wr_count + 16'd1;
                wr_blank <= BLANK_W'(FLAG_BLANK);
                last_rd  <= 1'b0;
            end else if (wr_blank != '0) begin
                wr_blank <= wr_blank - BLANK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ftdi_bus_arbiter.sv
// tb_ftdi_bus_arbiter
//   Directed scenarios for ftdi_bus_arbiter: reset values, single read, single write,
//   read/write contention with round-robin order, rx backpressure and reset mid-read.
//   Bus invariants are watched continuously by a negedge monitor.
module tb_ftdi_bus_arbiter;

    localparam int unsigned TURNAROUND = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ftdi_rxf = 1'b1;
    logic        ftdi_txe = 1'b1;
    logic [7:0]  adbus_in = 8'h00;
    logic [7:0]  adbus_out;
    logic        adbus_oe;
    logic        ftdi_rd;
    logic        ftdi_wr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ftdi_bus_arbiter #(
        .RD_PULSE   (3),
        .WR_PULSE   (2),
        .TURNAROUND (TURNAROUND),
        .FLAG_BLANK (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ftdi_rxf  (ftdi_rxf),
        .ftdi_txe  (ftdi_txe),
        .adbus_in  (adbus_in),
        .adbus_out (adbus_out),
        .adbus_oe  (adbus_oe),
        .ftdi_rd   (ftdi_rd),
        .ftdi_wr   (ftdi_wr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clock = ~clock;

    // Bus invariant monitor: RD# low never overlaps drive or WR# low, and RD# only
    // falls after more than TURNAROUND samples with the bus released.
    int unsigned viol     = 0;
    int unsigned since_oe = 100;
    logic        mon_prev_rd = 1'b1;
    always @(negedge clock) begin
        if (!reset) begin
            if (!ftdi_rd && adbus_oe) viol++;
            if (!ftdi_rd && !ftdi_wr) viol++;
            if (!ftdi_rd && mon_prev_rd && since_oe <= TURNAROUND) viol++;
        end
        if (adbus_oe)
            since_oe = 0;
        else if (since_oe < 100)
            since_oe++;
        mon_prev_rd = ftdi_rd;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset    = 1'b1;
        ftdi_rxf = 1'b1;
        ftdi_txe = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (ftdi_rd !== 1'b1) $display("FAIL reset_rd: got %b expected 1", ftdi_rd); else n_pass++;
        n_checks++;
        if (ftdi_wr !== 1'b1) $display("FAIL reset_wr: got %b expected 1", ftdi_wr); else n_pass++;
        n_checks++;
        if (adbus_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", adbus_oe); else n_pass++;
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); else n_pass++;
        n_checks++;
        if (rd_count !== 16'd0) $display("FAIL reset_rd_count: got %0d expected 0", rd_count); else n_pass++;
        n_checks++;
        if (wr_count !== 16'd0) $display("FAIL reset_wr_count: got %0d expected 0", wr_count); else n_pass++;
        n_checks++;
        if (adbus_out !== 8'h00) $display("FAIL reset_adbus_out: got %h expected 00", adbus_out); else n_pass++;
    endtask

    task automatic test_single_read();
        int unsigned low_cnt   = 0;
        int unsigned first_low = 0;
        int unsigned valid_at  = 0;
        int unsigned extra     = 0;
        bit          seen_low  = 1'b0;
        bit          seen_val  = 1'b0;
        logic        prev;
        @(negedge clock);
        adbus_in = 8'hA5;
        rx_ready = 1'b1;
        ftdi_rxf = 1'b0;
        for (int unsigned i = 1; i <= 30 && !seen_val; i++) begin
            @(negedge clock);
            if (!ftdi_rd) begin
                if (!seen_low) begin
                    seen_low  = 1'b1;
                    first_low = i;
                end
                low_cnt++;
            end
            if (rx_valid) begin
                seen_val = 1'b1;
                valid_at = i;
                ftdi_rxf = 1'b1;
            end
        end
        n_checks++;
        if (seen_val !== 1'b1) $display("FAIL read_valid_seen: got %b expected 1", seen_val); else n_pass++;
        n_checks++;
        if (low_cnt != 3) $display("FAIL read_rd_low_cycles: got %0d expected 3", low_cnt); else n_pass++;
        n_checks++;
        if (valid_at - first_low != 4)
            $display("FAIL read_latency: got %0d expected 4", valid_at - first_low);
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'hA5) $display("FAIL read_rx_data: got %h expected a5", rx_data); else n_pass++;
        prev = ftdi_rd;
        for (int unsigned i = 0; i < 12; i++) begin
            @(negedge clock);
            if (!ftdi_rd && prev) extra++;
            prev = ftdi_rd;
        end
        n_checks++;
        if (extra != 0) $display("FAIL read_one_byte: got %0d extra strobes expected 0", extra); else n_pass++;
        n_checks++;
        if (rd_count !== 16'd1) $display("FAIL read_rd_count: got %0d expected 1", rd_count); else n_pass++;
    endtask

    task automatic test_single_write();
        bit          found   = 1'b0;
        int unsigned pulses  = 0;
        @(negedge clock);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        ftdi_txe = 1'b0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (tx_ready) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL write_tx_ready_seen: got %b expected 1", found); else n_pass++;
        n_checks++;
        if (adbus_oe !== 1'b0) $display("FAIL write_setup_oe: got %b expected 0", adbus_oe); else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({ftdi_wr, adbus_oe, adbus_out, tx_ready} !== {1'b0, 1'b1, 8'h3C, 1'b0})
            $display("FAIL write_low1: got wr=%b oe=%b out=%h rdy=%b expected wr=0 oe=1 out=3c rdy=0",
                     ftdi_wr, adbus_oe, adbus_out, tx_ready);
        else n_pass++;
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        ftdi_txe = 1'b1;
        @(negedge clock);
        if (tx_ready) pulses++;
        n_checks++;
        if ({ftdi_wr, adbus_oe, adbus_out} !== {1'b0, 1'b1, 8'h3C})
            $display("FAIL write_low2: got wr=%b oe=%b out=%h expected wr=0 oe=1 out=3c",
                     ftdi_wr, adbus_oe, adbus_out);
        else n_pass++;
        @(negedge clock);
        if (tx_ready) pulses++;
        n_checks++;
        if ({ftdi_wr, adbus_oe, adbus_out} !== {1'b1, 1'b1, 8'h3C})
            $display("FAIL write_hold: got wr=%b oe=%b out=%h expected wr=1 oe=1 out=3c",
                     ftdi_wr, adbus_oe, adbus_out);
        else n_pass++;
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clock);
            if (tx_ready) pulses++;
            n_checks++;
            if ({ftdi_wr, adbus_oe} !== 2'b10)
                $display("FAIL write_turn%0d: got wr=%b oe=%b expected wr=1 oe=0", i, ftdi_wr, adbus_oe);
            else n_pass++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL write_single_ready: got %0d extra pulses expected 0", pulses); else n_pass++;
        n_checks++;
        if (wr_count !== 16'd1) $display("FAIL write_wr_count: got %0d expected 1", wr_count); else n_pass++;
    endtask

    task automatic test_contention();
        string       exp_s = "RWRWRW";
        logic [7:0]  seen [6];
        int unsigned n = 0;
        logic        prev;
        for (int k = 0; k < 6; k++) seen[k] = "-";
        repeat (8) @(negedge clock);
        adbus_in = 8'h11;
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        rx_ready = 1'b1;
        ftdi_rxf = 1'b0;
        ftdi_txe = 1'b0;
        prev = ftdi_rd;
        for (int unsigned i = 0; i < 200 && n < 6; i++) begin
            @(negedge clock);
            if (!ftdi_rd && prev && n < 6) begin
                seen[n] = "R";
                n++;
            end
            if (tx_ready && n < 6) begin
                seen[n] = "W";
                n++;
            end
            prev = ftdi_rd;
        end
        ftdi_rxf = 1'b1;
        ftdi_txe = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (20) @(negedge clock);
        n_checks++;
        if (n != 6) $display("FAIL contention_transfers: got %0d expected 6", n); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (seen[k] !== exp_s[k])
                $display("FAIL contention_order%0d: got %s expected %s", k, seen[k], exp_s[k]);
            else n_pass++;
        end
        n_checks++;
        if (rd_count !== 16'd4) $display("FAIL contention_rd_count: got %0d expected 4", rd_count); else n_pass++;
        n_checks++;
        if (wr_count !== 16'd4) $display("FAIL contention_wr_count: got %0d expected 4", wr_count); else n_pass++;
        n_checks++;
        if (viol != 0) $display("FAIL bus_invariants: got %0d violations expected 0", viol); else n_pass++;
    endtask

    task automatic test_backpressure();
        int unsigned reads = 0;
        bit          found = 1'b0;
        logic        prev;
        @(negedge clock);
        rx_ready = 1'b0;
        adbus_in = 8'h5A;
        ftdi_rxf = 1'b0;
        prev = ftdi_rd;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!ftdi_rd && prev) reads++;
            prev = ftdi_rd;
        end
        n_checks++;
        if (reads != 1) $display("FAIL bp_single_read: got %0d expected 1", reads); else n_pass++;
        n_checks++;
        if (rx_valid !== 1'b1) $display("FAIL bp_rx_valid_held: got %b expected 1", rx_valid); else n_pass++;
        n_checks++;
        if (rx_data !== 8'h5A) $display("FAIL bp_rx_data: got %h expected 5a", rx_data); else n_pass++;
        adbus_in = 8'h77;
        rx_ready = 1'b1;
        for (int unsigned i = 0; i < 12 && !found; i++) begin
            @(negedge clock);
            if (!ftdi_rd && prev) begin
                found    = 1'b1;
                ftdi_rxf = 1'b1;
            end
            prev = ftdi_rd;
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL bp_resume: got %b expected 1", found); else n_pass++;
        repeat (15) @(negedge clock);
        n_checks++;
        if (rd_count !== 16'd6) $display("FAIL bp_rd_count: got %0d expected 6", rd_count); else n_pass++;
        n_checks++;
        if (rx_data !== 8'h77) $display("FAIL bp_second_data: got %h expected 77", rx_data); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        bit          found = 1'b0;
        int unsigned late  = 0;
        @(negedge clock);
        rx_ready = 1'b1;
        adbus_in = 8'hC3;
        ftdi_rxf = 1'b0;
        for (int unsigned i = 0; i < 12 && !found; i++) begin
            @(negedge clock);
            if (!ftdi_rd) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL rst_read_started: got %b expected 1", found); else n_pass++;
        @(negedge clock);
        n_checks++;
        if (ftdi_rd !== 1'b0) $display("FAIL rst_rd_low2: got %b expected 0", ftdi_rd); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (ftdi_rd !== 1'b1) $display("FAIL rst_abort_rd: got %b expected 1", ftdi_rd); else n_pass++;
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL rst_abort_rx_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++;
        if (rd_count !== 16'd0) $display("FAIL rst_abort_rd_count: got %0d expected 0", rd_count); else n_pass++;
        reset    = 1'b0;
        ftdi_rxf = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rx_valid) late++;
        end
        n_checks++;
        if (late != 0) $display("FAIL rst_no_late_valid: got %0d cycles expected 0", late); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_backpressure();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
